// File: rtl/actel_cfg_loader.sv
// actel_cfg_loader
// ----------------
// Serial configuration loader for a bank of S1-style mux/flip-flop cells.
// It hunts for a sync byte on a bit-serial input and then shifts in
// 4*N_CELLS data bits, with the first bit landing in the MSB. A trailing
// even-parity bit follows. A frame with good parity is committed in one
// step to the parallel configuration register. A bad frame raises a
// one-cycle error pulse and leaves the register untouched.
//
// Ports
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   sdi        serial data bit
//   sdi_valid  sdi is consumed on a clock edge only when high
//   abort      synchronous abort; drops the frame in progress
//   cfg_data   committed configuration, cell k at [4k+3:4k] = {d11,d10,d01,d00}
//   cfg_valid  high once any frame has been committed since reset
//   cfg_stb    one-cycle pulse in the cycle after a commit
//   busy       high while loading data or waiting for the parity bit
//   err        one-cycle pulse in the cycle after a parity failure
module actel_cfg_loader #(
  parameter int          N_CELLS = 8,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   sdi,
  input  logic                   sdi_valid,
  input  logic                   abort,
  output logic [4*N_CELLS-1:0]   cfg_data,
  output logic                   cfg_valid,
  output logic                   cfg_stb,
  output logic                   busy,
  output logic                   err
);

  localparam int FW    = 4 * N_CELLS;
  localparam int CNT_W = (FW > 1) ? $clog2(FW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FW - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOAD   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_window;
  logic [FW-1:0]    r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [FW-1:0]    r_cfg_data;
  logic             r_cfg_valid;
  logic             r_cfg_stb;
  logic             r_busy;
  logic             r_err;

  logic [7:0]       w_win_next;
  logic             w_sync_hit;
  logic             w_par_bad;

  // Sync match is tested on the window value including the bit being consumed.
  assign w_win_next = {r_window[6:0], sdi};
  assign w_sync_hit = (w_win_next == SYNC);
  // Even parity over data plus parity bit: any odd count of ones is a failure.
  assign w_par_bad  = (^r_shadow) ^ sdi;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= HUNT;
      r_window    <= '0;
      r_shadow    <= '0;
      r_cnt       <= '0;
      r_cfg_data  <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_stb   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cfg_stb <= 1'b0;
      r_err     <= 1'b0;
      if (abort) begin
        // Abort takes priority over a bit presented on the same edge.
        r_state  <= HUNT;
        r_window <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b0;
      end else if (sdi_valid) begin
        case (r_state)
          HUNT: begin
            if (w_sync_hit) begin
              r_state  <= LOAD;
              r_window <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end else begin
              r_window <= w_win_next;
            end
          end
          LOAD: begin
            r_shadow <= {r_shadow[FW-2:0], sdi};
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            if (w_par_bad) begin
              r_err <= 1'b1;
            end else begin
              r_cfg_data  <= r_shadow;
              r_cfg_valid <= 1'b1;
              r_cfg_stb   <= 1'b1;
            end
            r_state  <= HUNT;
            r_window <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
          end
          default: begin
            r_state  <= HUNT;
            r_window <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_data  = r_cfg_data;
  assign cfg_valid = r_cfg_valid;
  assign cfg_stb   = r_cfg_stb;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
